// File: rtl/frame_stream_pkg.sv
// frame_stream_pkg
//   Shared types and constants for the frame pixel streamer.
//   FRAME_W/FRAME_H/N_PIXELS : default frame geometry (320x240 RGB444)
//   pixel_t    : one RGB444 pixel, packed {R[11:8], G[7:4], B[3:0]}
//   pix_addr_t : linear pixel index, wide enough for N_PIXELS
//   beat_t     : one output beat as stored in the skid FIFO
//   stream_state_t : streamer FSM states
//   bar_color  : vertical colour-bar generator used by the optional
//                test-pattern build (FRAME_STREAMER_TEST_PATTERN_EN)
package frame_stream_pkg;

  localparam int FRAME_W  = 320;
  localparam int FRAME_H  = 240;
  localparam int N_PIXELS = FRAME_W * FRAME_H;

  typedef logic [11:0] pixel_t;
  typedef logic [16:0] pix_addr_t;

  typedef struct packed {
    pixel_t    data;
    pix_addr_t addr;
    logic      sop;
    logic      eop;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } stream_state_t;

  // Four equal-width bars across a 320-pixel line: red, green, blue, white.
  function automatic pixel_t bar_color(input pix_addr_t col);
    if (col < pix_addr_t'(80))       return 12'hF00;
    else if (col < pix_addr_t'(160)) return 12'h0F0;
    else if (col < pix_addr_t'(240)) return 12'h00F;
    else                             return 12'hFFF;
  endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// pix_skid_fifo
//   Two-entry FIFO of beat_t sitting between the frame-buffer read path and
//   the valid/ready output. The head entry drives the output beat directly,
//   so it holds stable while the consumer stalls.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears contents)
//   push        : write push_beat this cycle
//   push_beat   : beat to write
//   pop         : retire the head entry this cycle
//   head        : current head entry (zero after reset)
//   full, empty : occupancy flags
//   count       : occupancy, 0..2
module pix_skid_fifo
  import frame_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  do_push;
  logic  do_pop;

  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so push while full is accepted
  // when paired with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer
//   Reads one frame from the frame-buffer RAM and streams it out as
//   valid/ready beats tagged with linear address, start- and end-of-packet.
//   Optional build macro: FRAME_STREAMER_TEST_PATTERN_EN replaces the RAM
//   data with vertical colour bars (read timing is unchanged).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   frame_start  : single-cycle request to stream a frame (IDLE only)
//   ram_addr     : frame-buffer read address
//   ram_rd       : read strobe; data returns on ram_rdata one cycle later
//   ram_rdata    : frame-buffer read data
//   pix_data     : output pixel
//   pix_address  : linear index of pix_data
//   pix_sop      : beat is pixel 0
//   pix_eop      : beat is pixel N-1
//   pix_valid    : output beat valid
//   pix_ready    : consumer accepts the beat
//   busy         : frame in progress, up to the eop accept
//   frame_done   : one-cycle pulse after the eop beat is accepted
module frame_pixel_streamer
  import frame_stream_pkg::*;
#(
  parameter int FRAME_W = frame_stream_pkg::FRAME_W,
  parameter int FRAME_H = frame_stream_pkg::FRAME_H,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic [ADDR_W-1:0] pix_address,
  output logic              pix_sop,
  output logic              pix_eop,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int        N_PIX     = FRAME_W * FRAME_H;
  localparam pix_addr_t LAST_ADDR = pix_addr_t'(N_PIX - 1);

  stream_state_t state;
  pix_addr_t     rd_addr;
  logic          in_flight;
  pix_addr_t     fl_addr;
  beat_t         push_beat;
  beat_t         head;
  logic          fifo_empty;
  logic          unused_fifo_full;
  logic [1:0]    fifo_count;
  logic          pop;
  logic          rd_go;
  logic          start_accept;
  logic          eop_accept;
  logic [2:0]    credit_used;

  assign pop          = !fifo_empty && pix_ready;
  assign eop_accept   = pop && head.eop;
  assign start_accept = (state == IDLE) && frame_start && !frame_done;

  // Credit counts the FIFO slots still owed after this cycle's pop plus the
  // read already in flight; counting the pop lets a read issue every cycle
  // under full throughput without ever overrunning the two entries.
  assign credit_used = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, in_flight};
  assign rd_go       = (state == STREAM) && (credit_used < 3'd2);

  assign ram_rd      = rd_go;
  assign ram_addr    = rd_addr;
  assign pix_valid   = !fifo_empty;
  assign pix_data    = head.data;
  assign pix_address = head.addr;
  assign pix_sop     = pix_valid && head.sop;
  assign pix_eop     = pix_valid && head.eop;

  // Frame sequencing: issue reads in STREAM, then wait in DRAIN until the
  // eop beat leaves so busy/frame_done line up with the final accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_addr    <= '0;
      in_flight  <= 1'b0;
      fl_addr    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      in_flight  <= rd_go;
      if (rd_go) begin
        fl_addr <= rd_addr;
      end
      case (state)
        IDLE: begin
          if (start_accept) begin
            state   <= STREAM;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        STREAM: begin
          if (rd_go) begin
            if (rd_addr == LAST_ADDR) begin
              state <= DRAIN;
            end else begin
              rd_addr <= rd_addr + pix_addr_t'(1);
            end
          end
        end
        DRAIN: begin
          if (eop_accept && !in_flight && fifo_count == 2'd1) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_STREAMER_TEST_PATTERN_EN
  localparam pix_addr_t LAST_COL = pix_addr_t'(FRAME_W - 1);

  pix_addr_t rd_col;
  pix_addr_t fl_col;
  logic      unused_rdata;

  assign unused_rdata = ^ram_rdata;

  // Column counter tracks rd_addr % FRAME_W so no divider is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_col <= '0;
      fl_col <= '0;
    end else begin
      if (start_accept) begin
        rd_col <= '0;
      end else if (rd_go && rd_addr != LAST_ADDR) begin
        rd_col <= (rd_col == LAST_COL) ? '0 : rd_col + pix_addr_t'(1);
      end
      if (rd_go) begin
        fl_col <= rd_col;
      end
    end
  end
`endif

  // Returning read data is tagged with the address it was issued at.
  always_comb begin
    push_beat.addr = fl_addr;
    push_beat.sop  = (fl_addr == '0);
    push_beat.eop  = (fl_addr == LAST_ADDR);
`ifdef FRAME_STREAMER_TEST_PATTERN_EN
    push_beat.data = bar_color(fl_col);
`else
    push_beat.data = ram_rdata;
`endif
  end

  pix_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// tb_frame_pixel_streamer
//   Scoreboard bench for frame_pixel_streamer. A reduced 320x2 frame keeps
//   every scenario short while still covering full line width, so the
//   colour-bar columns (FRAME_STREAMER_TEST_PATTERN_EN) are all reachable.
//   Expected beats are queued when a frame is requested and popped as the
//   DUT hands beats over.
module tb_frame_pixel_streamer;

  localparam int FRAME_W = 320;
  localparam int FRAME_H = 2;
  localparam int N       = FRAME_W * FRAME_H;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 12;
  localparam int BW      = DATA_W + ADDR_W + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              ram_rd;
  logic [DATA_W-1:0] pix_data;
  logic [ADDR_W-1:0] pix_address;
  logic              pix_sop;
  logic              pix_eop;
  logic              pix_valid;
  logic              pix_ready;
  logic              busy;
  logic              frame_done;

  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] exp_q [$];

  always #5 clk = ~clk;

  // Frame buffer with one-cycle read latency; contents are addr[11:0].
  always @(posedge clk) begin
    if (ram_rd) ram_rdata <= ram_addr[11:0];
  end

  frame_pixel_streamer #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .ram_addr    (ram_addr),
    .ram_rdata   (ram_rdata),
    .ram_rd      (ram_rd),
    .pix_data    (pix_data),
    .pix_address (pix_address),
    .pix_sop     (pix_sop),
    .pix_eop     (pix_eop),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  function automatic logic [DATA_W-1:0] exp_data(input int a);
`ifdef FRAME_STREAMER_TEST_PATTERN_EN
    int x;
    x = a % FRAME_W;
    if (x < 80)       return 12'hF00;
    else if (x < 160) return 12'h0F0;
    else if (x < 240) return 12'h00F;
    else              return 12'hFFF;
`else
    return a[11:0];
`endif
  endfunction

  task automatic push_frame();
    exp_q.delete();
    for (int a = 0; a < N; a++)
      exp_q.push_back({exp_data(a), ADDR_W'(a), (a == 0), (a == N - 1)});
  endtask

  // Called at a negedge; returns at the negedge after the request is taken.
  task automatic start_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pix_ready   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_addr, ram_rd} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ram: got addr=%0d rd=%b, expected 0/0", ram_addr, ram_rd);
    end
    checks++;
    if ({pix_valid, pix_sop, pix_eop, busy, frame_done} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got v/sop/eop/busy/done=%b%b%b%b%b, expected 00000",
               pix_valid, pix_sop, pix_eop, busy, frame_done);
    end
    checks++;
    if ({pix_data, pix_address} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: got data=%h addr=%0d, expected 0/0", pix_data, pix_address);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (ram_rd !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_quiet: cycle %0d got rd=%b busy=%b, expected 0/0", i, ram_rd, busy);
      end
    end
  endtask

  task automatic test_full_frame();
    int n, beats, done_pulses, eop_n;
    logic [BW-1:0] act, exp;
    pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    push_frame();
    start_frame();
    checks++;
    if (ram_rd !== 1'b1 || ram_addr !== '0) begin
      failures++;
      $display("[TB] FAIL first_read: got rd=%b addr=%0d, expected 1/0", ram_rd, ram_addr);
    end
    beats = 0; done_pulses = 0; eop_n = -1;
    for (n = 1; n < N + 20; n++) begin
      if (n == 2) begin
        checks++;
        if (pix_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL latency_early: got valid=%b at t+2, expected 0", pix_valid);
        end
      end
      if (n == 3) begin
        checks++;
        if (pix_valid !== 1'b1) begin
          failures++;
          $display("[TB] FAIL latency: got valid=%b at t+3, expected 1", pix_valid);
        end
      end
      if (frame_done === 1'b1) done_pulses++;
      if (eop_n >= 0 && n == eop_n + 1) begin
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b1) begin
          failures++;
          $display("[TB] FAIL done_timing: got busy=%b done=%b, expected 0/1", busy, frame_done);
        end
      end
      if (pix_valid && pix_ready) begin
        act = {pix_data, pix_address, pix_sop, pix_eop};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL full_extra_beat: got %h, expected no beat", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            failures++;
            $display("[TB] FAIL full_beat %0d: got %h, expected %h", beats, act, exp);
          end
        end
        beats++;
        if (pix_eop) begin
          eop_n = n;
          checks++;
          if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_at_eop: got %b, expected 1", busy);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (eop_n !== N + 2) begin
      failures++;
      $display("[TB] FAIL frame_length: got eop at t+%0d, expected t+%0d", eop_n, N + 2);
    end
    checks++;
    if (beats !== N || exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL full_count: got %0d beats (%0d left), expected %0d", beats, exp_q.size(), N);
    end
    checks++;
    if (done_pulses !== 1) begin
      failures++;
      $display("[TB] FAIL full_done_pulses: got %0d, expected 1", done_pulses);
    end
  endtask

  task automatic test_backpressure();
    int n, beats;
    logic done, prev_stall;
    logic [BW-1:0] act, exp, prev_act;
    pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    push_frame();
    start_frame();
    beats = 0; done = 1'b0; prev_stall = 1'b0; prev_act = '0;
    for (n = 0; n < 6 * N && !done; n++) begin
      pix_ready = 1'($urandom_range(0, 1));
      act = {pix_data, pix_address, pix_sop, pix_eop};
      if (prev_stall) begin
        checks++;
        if (pix_valid !== 1'b1 || act !== prev_act) begin
          failures++;
          $display("[TB] FAIL stall_hold: got v=%b %h, expected v=1 %h", pix_valid, act, prev_act);
        end
      end
      checks++;
      if (dut.u_fifo.count > 2'd2) begin
        failures++;
        $display("[TB] FAIL fifo_count: got %0d, expected <= 2", dut.u_fifo.count);
      end
      if (frame_done === 1'b1) done = 1'b1;
      if (pix_valid && pix_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL bp_extra_beat: got %h, expected no beat", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            failures++;
            $display("[TB] FAIL bp_beat %0d: got %h, expected %h", beats, act, exp);
          end
        end
        beats++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_act   = act;
      @(negedge clk);
    end
    pix_ready = 1'b1;
    checks++;
    if (!done || beats !== N || exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL bp_complete: got done=%b beats=%0d left=%0d, expected 1/%0d/0",
               done, beats, exp_q.size(), N);
    end
  endtask

  task automatic test_restart_ignored();
    int n, beats, done_pulses, done_n;
    logic [BW-1:0] act, exp;
    pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    push_frame();
    start_frame();
    beats = 0; done_pulses = 0; done_n = -1;
    for (n = 1; n < N + 30; n++) begin
      frame_start = 1'b0;
      if (done_n >= 0 && n > done_n) begin
        checks++;
        if (busy !== 1'b0 || ram_rd !== 1'b0) begin
          failures++;
          $display("[TB] FAIL start_on_done: got busy=%b rd=%b, expected 0/0", busy, ram_rd);
        end
      end
      if (frame_done === 1'b1) begin
        done_pulses++;
        done_n      = n;
        frame_start = 1'b1;
      end
      if (pix_valid && pix_ready) begin
        act = {pix_data, pix_address, pix_sop, pix_eop};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL restart_extra_beat: got %h, expected no beat", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            failures++;
            $display("[TB] FAIL restart_beat %0d: got %h, expected %h", beats, act, exp);
          end
        end
        if (beats == 300) frame_start = 1'b1;
        beats++;
      end
      @(negedge clk);
    end
    frame_start = 1'b0;
    checks++;
    if (beats !== N || done_pulses !== 1) begin
      failures++;
      $display("[TB] FAIL restart_count: got beats=%0d done=%0d, expected %0d/1", beats, done_pulses, N);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, beats, done_pulses;
    logic [BW-1:0] act, exp;
    pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    push_frame();
    start_frame();
    beats = 0;
    for (n = 1; n < N + 20 && rst_n; n++) begin
      if (pix_valid && pix_ready) begin
        act = {pix_data, pix_address, pix_sop, pix_eop};
        checks++;
        exp = exp_q.pop_front();
        if (act !== exp) begin
          failures++;
          $display("[TB] FAIL pre_reset_beat %0d: got %h, expected %h", beats, act, exp);
        end
        if (beats == 500) rst_n = 1'b0;
        beats++;
      end
      @(negedge clk);
    end
    checks++;
    if (rst_n !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset: got rst=%b valid=%b busy=%b, expected 0/0/0", rst_n, pix_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || pix_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL abandoned: got done=%b valid=%b, expected 0/0", frame_done, pix_valid);
      end
    end
    push_frame();
    start_frame();
    beats = 0; done_pulses = 0;
    for (n = 1; n < N + 20; n++) begin
      if (frame_done === 1'b1) done_pulses++;
      if (pix_valid && pix_ready) begin
        act = {pix_data, pix_address, pix_sop, pix_eop};
        if (beats == 0) begin
          checks++;
          if (pix_address !== '0 || pix_sop !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_sop: got addr=%0d sop=%b, expected 0/1", pix_address, pix_sop);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL post_reset_extra: got %h, expected no beat", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            failures++;
            $display("[TB] FAIL post_reset_beat %0d: got %h, expected %h", beats, act, exp);
          end
        end
        beats++;
      end
      @(negedge clk);
    end
    checks++;
    if (beats !== N || done_pulses !== 1) begin
      failures++;
      $display("[TB] FAIL post_reset_count: got beats=%0d done=%0d, expected %0d/1", beats, done_pulses, N);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pix_ready   = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
